// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths, link register and write-back source enum
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NREG     = 32;
    localparam int ADDR_W   = $clog2(NREG);
    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB inputs, ID read ports and forwarding export
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic              I_WB_RegWrite;
    logic              I_WB_MemtoReg;
    logic [DATA_W-1:0] I_ReDat_Mem;
    logic [DATA_W-1:0] I_ALU_Res;
    logic [ADDR_W-1:0] I_Addr_Reg_Wri;
    logic              I_Jump;
    logic [DATA_W-1:0] I_Ins32_J;
    logic [ADDR_W-1:0] I_Addr_Rs;
    logic [ADDR_W-1:0] I_Addr_Rt;
    logic [DATA_W-1:0] O_Dat_Rs;
    logic [DATA_W-1:0] O_Dat_Rt;
    logic              O_WB_En;
    logic [ADDR_W-1:0] O_WB_Addr;
    logic [DATA_W-1:0] O_WB_Data;
    logic [31:0]       O_Wr_Count;

    modport master (
        output I_WB_RegWrite, I_WB_MemtoReg, I_ReDat_Mem, I_ALU_Res, I_Addr_Reg_Wri,
               I_Jump, I_Ins32_J, I_Addr_Rs, I_Addr_Rt,
        input  O_Dat_Rs, O_Dat_Rt, O_WB_En, O_WB_Addr, O_WB_Data, O_Wr_Count
    );

    modport slave (
        input  I_WB_RegWrite, I_WB_MemtoReg, I_ReDat_Mem, I_ALU_Res, I_Addr_Reg_Wri,
               I_Jump, I_Ins32_J, I_Addr_Rs, I_Addr_Rt,
        output O_Dat_Rs, O_Dat_Rt, O_WB_En, O_WB_Addr, O_WB_Data, O_Wr_Count
    );

endinterface

// File: rtl/wb_regfile_core.sv
// rtl/wb_regfile_core.sv - register array with sync reset, one write and two read ports, r0 hardwired
module regfile_core #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREG];

    // Reset wins over a write presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, register file, forwarding export; WB_BYPASS_EN enables write-first reads
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = wb_regfile_pkg::DATA_W,
    parameter int NREG     = wb_regfile_pkg::NREG,
    parameter int LINK_REG = wb_regfile_pkg::LINK_REG
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    wb_src_e           src;
    logic              want_wr;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] core_rs;
    logic [DATA_W-1:0] core_rt;
    logic [31:0]       wr_count;

    // Jump-and-link outranks a normal write and ignores RegWrite
    always_comb begin
        src     = SRC_ALU;
        want_wr = 1'b0;
        if (bus.I_Jump) begin
            src     = SRC_LINK;
            want_wr = 1'b1;
        end else if (bus.I_WB_RegWrite) begin
            src     = bus.I_WB_MemtoReg ? SRC_MEM : SRC_ALU;
            want_wr = 1'b1;
        end
    end

    always_comb begin
        wb_addr = (src == SRC_LINK) ? AW'(LINK_REG) : bus.I_Addr_Reg_Wri;
        case (src)
            SRC_MEM:  wb_data = bus.I_ReDat_Mem;
            SRC_LINK: wb_data = bus.I_Ins32_J;
            default:  wb_data = bus.I_ALU_Res;
        endcase
        wb_en = want_wr && (wb_addr != '0);
    end

    regfile_core #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (bus.I_Addr_Rs),
        .raddr_b (bus.I_Addr_Rt),
        .rdata_a (core_rs),
        .rdata_b (core_rt)
    );

`ifdef WB_BYPASS_EN
    // wb_en already excludes r0; bypass is held off while the array is being cleared
    always_comb begin
        bus.O_Dat_Rs = (!rst && wb_en && (bus.I_Addr_Rs == wb_addr)) ? wb_data : core_rs;
        bus.O_Dat_Rt = (!rst && wb_en && (bus.I_Addr_Rt == wb_addr)) ? wb_data : core_rt;
    end
`else
    assign bus.O_Dat_Rs = core_rs;
    assign bus.O_Dat_Rt = core_rt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wb_en) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    assign bus.O_WB_En    = wb_en;
    assign bus.O_WB_Addr  = wb_addr;
    assign bus.O_WB_Data  = wb_data;
    assign bus.O_Wr_Count = wr_count;

endmodule
